// File: rtl/store_pack_fifo_if.sv
// Store request / DM write handshake bundle for store_pack_fifo.
// The slave side is the FIFO; the master side is the store issue and DM port.
interface store_pack_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_addr;
  logic [31:0]      in_data;
  logic [1:0]       in_size;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [3:0]       out_be;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;

  modport slave (
    input  in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_be, count, full, empty, err
  );

  modport master (
    output in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_be, count, full, empty, err
  );
endinterface

// File: rtl/store_pack_fifo.sv
// Packs sb/sh/sw register data into word-aligned write data plus byte enables and queues it for DM.
// Optional macro STORE_ALIGN_CHECK_EN rejects misaligned halfword/word stores like reserved size.
module store_pack_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  store_pack_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d;
  entry_t           new_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             full_c, accept_c, legal_c, push_c, pop_c;

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign accept_c = bus.in_valid && !full_c;
  assign pop_c    = out_valid_q && bus.out_ready;

  // Lane replication, byte-enable generation and legality of the incoming request
  always_comb begin
    new_entry      = '0;
    new_entry.addr = {bus.in_addr[31:2], 2'b00};
    legal_c        = 1'b1;
    case (size_e'(bus.in_size))
      SZ_BYTE: begin
        new_entry.data = {4{bus.in_data[7:0]}};
        new_entry.be   = 4'b0001 << bus.in_addr[1:0];
      end
      SZ_HALF: begin
        new_entry.data = {2{bus.in_data[15:0]}};
        new_entry.be   = bus.in_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_ALIGN_CHECK_EN
        if (bus.in_addr[0]) legal_c = 1'b0;
`endif
      end
      SZ_WORD: begin
        new_entry.data = bus.in_data;
        new_entry.be   = 4'b1111;
`ifdef STORE_ALIGN_CHECK_EN
        if (bus.in_addr[1:0] != 2'b00) legal_c = 1'b0;
`endif
      end
      SZ_RSVD: legal_c = 1'b0;
    endcase
  end

  // Next-state: pointers, occupancy, and the head register that feeds the DM port
  always_comb begin
    push_c      = accept_c && legal_c;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_d      = head_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    out_valid_d = (count_d != '0);
    err_d       = accept_c && !legal_c;
    // The new head is the entry being written this cycle when it lands at the next read slot
    if (out_valid_d) begin
      head_d = (push_c && (rd_ptr_d == wr_ptr_q)) ? new_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Payload storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= new_entry;
  end

  assign bus.in_ready  = !full_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = head_q.addr;
  assign bus.out_data  = head_q.data;
  assign bus.out_be    = head_q.be;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = (count_q == '0);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_store_pack_fifo.sv
// Bench for store_pack_fifo: constant vector table, scoreboard monitor and multi-cycle sequences.
module tb_store_pack_fifo;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        ok;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  store_pack_fifo_if #(.DEPTH(DEPTH)) bus();
  store_pack_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   model_cnt = 0;
  logic err_exp = 1'b0;
  logic mon_en = 1'b0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packing built lane by lane
  function automatic exp_t model_pack(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] data);
    exp_t e;
    e.addr = addr & 32'hFFFF_FFFC;
    e.data = '0;
    e.be   = '0;
    e.ok   = (size != 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
    if (size == 2'b01 && addr[0]) e.ok = 1'b0;
    if (size == 2'b10 && addr[1:0] != 2'b00) e.ok = 1'b0;
`endif
    for (int lane = 0; lane < 4; lane++) begin
      logic [7:0] b;
      logic       en;
      case (size)
        2'b00: begin b = data[7:0]; en = (lane == int'(addr[1:0])); end
        2'b01: begin b = (lane % 2 == 1) ? data[15:8] : data[7:0]; en = ((lane / 2) == int'(addr[1])); end
        default: begin b = data[lane*8 +: 8]; en = 1'b1; end
      endcase
      e.data[lane*8 +: 8] = b;
      e.be[lane]          = en;
    end
    return e;
  endfunction

  // Scoreboard monitor: sampled mid-cycle, when inputs and outputs are both settled
  always @(negedge clk) begin
    int   cnt0;
    exp_t e;
    if (mon_en && reset_n) begin
      cnt0 = model_cnt;
      chk("count", 32'(bus.count), 32'(cnt0));
      chk("full", 32'(bus.full), 32'(cnt0 == DEPTH));
      chk("empty", 32'(bus.empty), 32'(cnt0 == 0));
      chk("in_ready", 32'(bus.in_ready), 32'(cnt0 != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(cnt0 != 0));
      chk("err", 32'(bus.err), 32'(err_exp));
      err_exp = 1'b0;
      if (cnt0 > 0) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 32'(0), 32'(1));
        end else begin
          chk("head_addr", bus.out_addr, sb_q[0].addr);
          chk("head_data", bus.out_data, sb_q[0].data);
          chk("head_be", 32'(bus.out_be), 32'(sb_q[0].be));
          if (bus.out_ready) begin
            void'(sb_q.pop_front());
            model_cnt--;
          end
        end
      end
      if (bus.in_valid && cnt0 != DEPTH) begin
        e = model_pack(bus.in_size, bus.in_addr, bus.in_data);
        if (e.ok) begin
          sb_q.push_back(e);
          model_cnt++;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_size   = s;
    bus.in_addr   = a;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"sb_lane3", 2'b00, 32'h0000_1003, 32'h1234_56AB, 1'b1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 1'b0};
    vecs[1] = '{"sh_hi", 2'b01, 32'h0000_2002, 32'hFFFF_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0};
    vecs[2] = '{"sh_lo", 2'b01, 32'h0000_3000, 32'h0000_CAFE, 1'b1, 32'h0000_3000, 32'hCAFE_CAFE, 4'b0011, 1'b0};
    vecs[3] = '{"sb_lane1", 2'b00, 32'h0000_4001, 32'h0000_005A, 1'b1, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0010, 1'b0};
    vecs[4] = '{"sw", 2'b10, 32'h0000_5000, 32'hDEAD_BEEF, 1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b1111, 1'b0};
    vecs[5] = '{"rsvd", 2'b11, 32'h0000_6000, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
`ifdef STORE_ALIGN_CHECK_EN
    vecs[6] = '{"sw_mis", 2'b10, 32'h0000_0006, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vecs[7] = '{"sh_mis", 2'b01, 32'h0000_7001, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
`else
    vecs[6] = '{"sw_mis", 2'b10, 32'h0000_0006, 32'hCAFE_F00D, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'b1111, 1'b0};
    vecs[7] = '{"sh_mis", 2'b01, 32'h0000_7001, 32'h1234_5678, 1'b1, 32'h0000_7000, 32'h5678_5678, 4'b0011, 1'b0};
`endif

    reset_n = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_empty", 32'(bus.empty), 32'(1));
    chk("rst_full", 32'(bus.full), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_addr", bus.out_addr, 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_be", 32'(bus.out_be), 32'(0));
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc();

    // Single requests into an empty FIFO: visible one edge later, then drained
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].size, vecs[i].addr, vecs[i].data, 1'b0);
      cyc();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      chk({vecs[i].name, "_err"}, 32'(bus.err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_valid) begin
        chk({vecs[i].name, "_addr"}, bus.out_addr, vecs[i].exp_addr);
        chk({vecs[i].name, "_data"}, bus.out_data, vecs[i].exp_data);
        chk({vecs[i].name, "_be"}, 32'(bus.out_be), 32'(vecs[i].exp_be));
      end
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
    end

    // Fill to full, hold a blocked request, then drain while it retries
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b10, 32'h0000_0100 + 32'(4 * i), 32'(i), 1'b0);
      cyc();
    end
    drive(1'b1, 2'b10, 32'h0000_0200, 32'd5, 1'b0);
    @(negedge clk);
    chk("full_flag", 32'(bus.full), 32'(1));
    chk("full_in_ready", 32'(bus.in_ready), 32'(0));
    cyc();
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", 32'(bus.empty), 32'(1));
    chk("drain_sb", 32'(sb_q.size()), 32'(0));
    cyc();

    // Steady push+pop at occupancy 3 across several pointer wraps
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
      cyc();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b00, 32'h0000_2000 + 32'(i), 32'h0000_0040 + 32'(i), 1'b1);
      cyc();
      chk("wrap_count", 32'(bus.count), 32'(3));
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    repeat (4) cyc();
    chk("wrap_sb", 32'(sb_q.size()), 32'(0));

    // out_ready on an empty FIFO must not disturb the pointers
    repeat (3) cyc();
    drive(1'b1, 2'b01, 32'h0000_3002, 32'h0000_7E57, 1'b1);
    cyc();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    repeat (2) cyc();
    chk("empty_rd_sb", 32'(sb_q.size()), 32'(0));
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-cycle with two entries queued and err high
    drive(1'b1, 2'b10, 32'h0000_4000, 32'h0000_00C1, 1'b0);
    cyc();
    drive(1'b1, 2'b10, 32'h0000_4004, 32'h0000_00C2, 1'b0);
    cyc();
    drive(1'b1, 2'b11, 32'h0000_4008, 32'h0000_00C3, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("arst_count", 32'(bus.count), 32'(0));
    chk("arst_err", 32'(bus.err), 32'(0));
    chk("arst_empty", 32'(bus.empty), 32'(1));
    sb_q.delete();
    model_cnt = 0;
    err_exp   = 1'b0;
    cyc();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc();
    drive(1'b1, 2'b00, 32'h0000_5002, 32'h0000_0077, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    repeat (2) cyc();
    bus.out_ready = 1'b0;
    chk("post_rst_sb", 32'(sb_q.size()), 32'(0));
    cyc();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_pack_fifo.md
Name: store_pack_fifo

Overview:
- Store-side counterpart of the immediate/load extension path: narrows 32-bit register data for sb/sh/sw into word-aligned write data plus a byte-enable mask.
- Buffers the packed stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Sits between the MEM-stage store issue and the DM write port, so the pipeline can retire stores while DM is busy.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  store request valid.
- in_ready  output  1  FIFO can accept a request.
- in_addr  input  32  byte address of the store.
- in_data  input  32  rt register value; only the low bytes named by in_size are used.
- in_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
- out_valid  output  1  head entry valid.
- out_ready  input  1  DM accepts the head entry.
- out_addr  output  32  word-aligned address; bits [1:0] are always 0.
- out_data  output  32  lane-replicated write data.
- out_be  output  4  byte enables; bit i enables byte lane i.
- count  output  CNT_W  current occupancy.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- err  output  1  one-cycle pulse for a rejected request.

Behaviour:
- Reset: asserting reset_n low asynchronously clears the pointers, count, out_valid, out_addr, out_data, out_be and err to 0. Any entries in flight are discarded. full=0, empty=1.
- Handshakes:
  - in_ready = !full, registered-derived; no combinational path from out_ready.
  - Push occurs when in_valid && in_ready and the request is legal.
  - Pop occurs when out_valid && out_ready.
- Packing at push:
  - Byte: data={4{in_data[7:0]}}, be=4'b0001<<in_addr[1:0].
  - Half: data={2{in_data[15:0]}}, be = in_addr[1] ? 4'b1100 : 4'b0011.
  - Word: data=in_data, be=4'b1111.
  - Stored address is {in_addr[31:2],2'b00}.
- Reserved size 11: request is consumed (in_ready is honoured) but not enqueued; err pulses.
- Latency: a push into an empty FIFO appears on out_valid on the next rising edge. There is no same-cycle fall-through.
- out_addr, out_data and out_be are driven from head-entry registers. They must hold stable while out_valid && !out_ready.
- Simultaneous push and pop with count>0: count unchanged; both pointers advance.
- Full: in_ready=0; in_valid is ignored. A pop in the same cycle frees a slot that becomes visible on the next cycle.
- Empty: out_valid=0; out_ready is ignored and the pointers do not move.
- Wrap-around: pointers are modulo DEPTH; FIFO order is preserved across the wrap.
- err is registered. It is high for exactly one cycle after the rejected request's accept edge, otherwise 0.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined: the following requests are consumed, not enqueued, and pulse err exactly like reserved size:
  - half with in_addr[0]=1;
  - word with in_addr[1:0]!=0.
- Not defined: address bits below the access size are ignored. Half uses in_addr[1] only; word ignores in_addr[1:0]. These requests are enqueued normally. err pulses only for reserved size.

Test Plan:
- Reset then sb addr=0x0000_1003 data=0x1234_56AB -> next cycle out_valid=1, out_addr=0x0000_1000, out_data=0xABAB_ABAB, out_be=4'b1000, count=1.
- sh addr=0x0000_2002 data=0xFFFF_BEEF with out_ready=1 -> out_data=0xBEEF_BEEF, out_be=4'b1100; popped on the following edge, empty=1.
- Push 4 sw (data 1..4) with out_ready=0 -> full=1, in_ready=0; a 5th in_valid is ignored. Then out_ready=1 -> data 1,2,3,4 drain in order over 4 cycles.
- Fill 3 entries, then push and pop in the same cycle repeatedly across the pointer wrap -> count stays 3 and the output order matches input order.
- in_size=11 -> no enqueue, count unchanged, err=1 for exactly one cycle. With STORE_ALIGN_CHECK_EN, sw addr=0x0000_0006 behaves the same. Without it, the same sw is enqueued with out_addr=0x0000_0004, be=4'b1111.
- With 2 entries queued and out_valid=1, pull reset_n low mid-cycle -> out_valid, count and err drop to 0 immediately, before the next edge.
